pipeline_hazard_controller: RTL and testbench

//  Sequences the 5-stage pipeline around the opcode decoder: owns PC/IF-ID write enables, the IF-ID/ID-EX

---
 rtl/pipeline_hazard_controller_if.sv | 47 ++++
 rtl/pipeline_hazard_controller.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller interface: pipeline status flowing into the controller
// and the pipeline-register controls flowing back out.
// Optional feature macro: HAZARD_PERF_COUNTERS_EN adds StallCycles/FlushCount.
interface pipeline_hazard_controller_if;
  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        IFID_UsesRt;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic        Jump;
  logic        BranchTaken;
  logic        MemReq;
  logic        MemReady;
  logic        PCWrite;
  logic        IFID_WriteEnable;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic [2:0]  StageWriteEnable;
  logic        MemError;
  logic [1:0]  HazardState;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] StallCycles;
  logic [15:0] FlushCount;
`endif

  // Pipeline/decoder side: reports hazards, consumes the enables.
  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
           Jump, BranchTaken, MemReq, MemReady,
    input  PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Flush,
           StageWriteEnable, MemError, HazardState
`ifdef HAZARD_PERF_COUNTERS_EN
    , input StallCycles, FlushCount
`endif
  );

  // Controller side.
  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
           Jump, BranchTaken, MemReq, MemReady,
    output PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Flush,
           StageWriteEnable, MemError, HazardState
`ifdef HAZARD_PERF_COUNTERS_EN
    , output StallCycles, FlushCount
`endif
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage pipeline hazard controller: load-use stalls, branch/jump squashing
// and frozen-pipeline waits on slow data-memory accesses with a timeout.
// All control outputs are combinational from the state and the current inputs.
// Optional feature macro: HAZARD_PERF_COUNTERS_EN (stall/flush counters).
module pipeline_hazard_controller #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,   // 1..7
  parameter int unsigned MEM_TIMEOUT      = 15   // 2..255
) (
  input logic                         Clk,
  input logic                         Rst,
  pipeline_hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    RUN        = 2'b01,
    LOAD_STALL = 2'b10,
    MEM_WAIT   = 2'b11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idex_flush;
    logic [2:0] stage_we;
  } ctl_t;

  localparam ctl_t CTL_FREEZE = '0;
  localparam ctl_t CTL_NORMAL = '{pc_write: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                  idex_flush: 1'b0, stage_we: 3'b111};
  localparam ctl_t CTL_BRANCH = '{pc_write: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                  idex_flush: 1'b1, stage_we: 3'b111};
  localparam ctl_t CTL_JUMP   = '{pc_write: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                  idex_flush: 1'b0, stage_we: 3'b111};
  localparam ctl_t CTL_STALL  = '{pc_write: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                  idex_flush: 1'b1, stage_we: 3'b111};

  localparam logic [2:0] BUBBLES = 3'(LOAD_USE_BUBBLES);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [2:0] bubble_cnt, bubble_cnt_nxt, bubble_inc;
  logic       resume_stall, resume_stall_nxt;  // MEM_WAIT was entered from LOAD_STALL
  logic       mem_error, set_mem_error;
  logic       released;
  logic       mem_wait, load_use, in_stall;
  ctl_t       ctl;

  assign mem_wait = bus.MemReq & ~bus.MemReady;
  assign load_use = bus.IDEX_MemRead && (bus.IDEX_Rt != 5'd0) &&
                    ((bus.IDEX_Rt == bus.IFID_Rs) ||
                     (bus.IFID_UsesRt && (bus.IDEX_Rt == bus.IFID_Rt)));
  // A wait that interrupted a stall resumes that stall on release.
  assign in_stall   = (state == LOAD_STALL) || ((state == MEM_WAIT) && resume_stall);
  assign bubble_inc = (bubble_cnt == 3'd7) ? bubble_cnt : bubble_cnt + 3'd1;

  // Next-state, counter and control decode. A memory release cycle is decided
  // by the same priority rules as the state it interrupted, with the memory
  // wait masked, so held branches/jumps act on release and stalls continue.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    ctl              = CTL_FREEZE;
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    bubble_cnt_nxt   = bubble_cnt;
    resume_stall_nxt = resume_stall;
    set_mem_error    = 1'b0;
    released         = 1'b0;

    case (state)
      IDLE: state_nxt = RUN;
      MEM_WAIT: begin
        if (bus.MemReady || (wait_cnt >= TIMEOUT)) begin
          released      = 1'b1;
          set_mem_error = ~bus.MemReady;
        end else if (wait_cnt != 8'hff) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: ;
    endcase

    if ((state == RUN) || (state == LOAD_STALL) || released) begin
      if (mem_wait && !released) begin
        ctl              = CTL_FREEZE;
        state_nxt        = MEM_WAIT;
        wait_cnt_nxt     = 8'd1;
        resume_stall_nxt = (state == LOAD_STALL);
      end else if (bus.BranchTaken) begin
        ctl       = CTL_BRANCH;
        state_nxt = RUN;
      end else if (in_stall) begin
        ctl            = CTL_STALL;
        bubble_cnt_nxt = bubble_inc;
        state_nxt      = (bubble_inc >= BUBBLES) ? RUN : LOAD_STALL;
      end else if (bus.Jump) begin
        ctl       = CTL_JUMP;
        state_nxt = RUN;
      end else if (load_use) begin
        ctl            = CTL_STALL;
        bubble_cnt_nxt = 3'd1;
        state_nxt      = (BUBBLES <= 3'd1) ? RUN : LOAD_STALL;
      end else begin
        ctl       = CTL_NORMAL;
        state_nxt = RUN;
      end
    end
  end

  // State and counter registers; MemError is sticky until reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      bubble_cnt   <= '0;
      resume_stall <= 1'b0;
      mem_error    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      bubble_cnt   <= bubble_cnt_nxt;
      resume_stall <= resume_stall_nxt;
      if (set_mem_error) mem_error <= 1'b1;
    end
  end

  assign bus.PCWrite          = ~Rst & ctl.pc_write;
  assign bus.IFID_WriteEnable = ~Rst & ctl.ifid_we;
  assign bus.IFID_Flush       = ~Rst & ctl.ifid_flush;
  assign bus.IDEX_Flush       = ~Rst & ctl.idex_flush;
  assign bus.StageWriteEnable = Rst ? 3'b000 : ctl.stage_we;
  assign bus.MemError         = ~Rst & mem_error;
  assign bus.HazardState      = Rst ? 2'b00 : state;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  // Saturating counts of PC-frozen cycles (outside IDLE) and IF-ID flushes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((state != IDLE) && !ctl.pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (ctl.ifid_flush && (flush_count != '1))
        flush_count <= flush_count + 16'd1;
    end
  end

  assign bus.StallCycles = Rst ? 32'd0 : stall_cycles;
  assign bus.FlushCount  = Rst ? 16'd0 : flush_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Testbench for pipeline_hazard_controller: two instances with different
// bubble/timeout parameters share one stimulus stream (directed scenarios,
// then random traffic) and are compared every cycle to a behavioural model.
module tb_pipeline_hazard_controller;

  localparam int N = 2;

  function automatic int bub_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int tmo_of(input int k);
    return (k == 0) ? 15 : 4;
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_mem_read, jump, branch_taken, mem_req, mem_ready;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if bus_a ();
  pipeline_hazard_controller_if bus_b ();

  assign bus_a.IFID_Rs = ifid_rs;           assign bus_b.IFID_Rs = ifid_rs;
  assign bus_a.IFID_Rt = ifid_rt;           assign bus_b.IFID_Rt = ifid_rt;
  assign bus_a.IFID_UsesRt = ifid_uses_rt;  assign bus_b.IFID_UsesRt = ifid_uses_rt;
  assign bus_a.IDEX_MemRead = idex_mem_read; assign bus_b.IDEX_MemRead = idex_mem_read;
  assign bus_a.IDEX_Rt = idex_rt;           assign bus_b.IDEX_Rt = idex_rt;
  assign bus_a.Jump = jump;                 assign bus_b.Jump = jump;
  assign bus_a.BranchTaken = branch_taken;  assign bus_b.BranchTaken = branch_taken;
  assign bus_a.MemReq = mem_req;            assign bus_b.MemReq = mem_req;
  assign bus_a.MemReady = mem_ready;        assign bus_b.MemReady = mem_ready;

  pipeline_hazard_controller #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(15)) dut_a (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_a)
  );

  pipeline_hazard_controller #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(4)) dut_b (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // What the pipeline does this cycle, and the control word each action implies.
  typedef enum int {A_OFF, A_NORMAL, A_FREEZE, A_STALL, A_BRANCH, A_JUMP} action_e;

  // {PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Flush, StageWriteEnable}
  function automatic logic [6:0] controls_for(input action_e a);
    case (a)
      A_NORMAL: return 7'b1100_111;
      A_STALL:  return 7'b0001_111;
      A_BRANCH: return 7'b1111_111;
      A_JUMP:   return 7'b1110_111;
      default:  return 7'b0000_000;
    endcase
  endfunction

  int phase   [N];  // 0 idle, 1 running, 2 extra load-use bubbles, 3 waiting on memory
  int bubbles [N];  // bubbles issued for the current load-use hazard
  int waited  [N];  // memory-wait cycles so far
  bit resume  [N];  // the wait interrupted a bubble sequence
  bit err     [N];
  int stalls  [N];
  int flushes [N];

  // Decide this cycle's action from the rules, return expected outputs
  // (pre-edge) and advance the model across the coming edge.
  task automatic model_step(input int k, output logic [6:0] e_ctl, output int e_hs,
                            output int e_err, output int e_stalls, output int e_flushes);
    action_e act;
    int  cur;
    bit  mw, lu, rel, stalling;
    if (rst) begin
      e_ctl = '0; e_hs = 0; e_err = 0; e_stalls = 0; e_flushes = 0;
      phase[k] = 0; bubbles[k] = 0; waited[k] = 0; resume[k] = 0;
      err[k] = 0; stalls[k] = 0; flushes[k] = 0;
      return;
    end
    cur = phase[k];
    e_hs = cur; e_err = err[k]; e_stalls = stalls[k]; e_flushes = flushes[k];
    mw  = mem_req && !mem_ready;
    lu  = idex_mem_read && idex_rt != 0 &&
          (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
    rel = 0;
    act = A_OFF;
    stalling = (cur == 2) || (cur == 3 && resume[k]);
    if (cur == 0) phase[k] = 1;
    if (cur == 3) begin
      if (mem_ready || waited[k] == tmo_of(k)) begin
        rel = 1;
        if (!mem_ready) err[k] = 1;
      end else begin
        act = A_FREEZE;
        waited[k]++;
      end
    end
    if (cur == 1 || cur == 2 || rel) begin
      if (mw && !rel) begin
        act = A_FREEZE; resume[k] = (cur == 2); phase[k] = 3; waited[k] = 1;
      end else if (branch_taken) begin
        act = A_BRANCH; phase[k] = 1;
      end else if (stalling) begin
        act = A_STALL; bubbles[k]++;
        phase[k] = (bubbles[k] >= bub_of(k)) ? 1 : 2;
      end else if (jump) begin
        act = A_JUMP; phase[k] = 1;
      end else if (lu) begin
        act = A_STALL; bubbles[k] = 1;
        phase[k] = (bub_of(k) == 1) ? 1 : 2;
      end else begin
        act = A_NORMAL; phase[k] = 1;
      end
    end
    if (cur != 0 && (act == A_FREEZE || act == A_STALL)) stalls[k]++;
    if (act == A_BRANCH || act == A_JUMP) flushes[k]++;
    e_ctl = controls_for(act);
  endtask

  task automatic get_obs(input int k, output logic [6:0] o_ctl, output logic [1:0] o_hs,
                         output logic o_err, output logic [31:0] o_st, output logic [31:0] o_fl);
    o_st = '0; o_fl = '0;
    if (k == 0) begin
      o_ctl = {bus_a.PCWrite, bus_a.IFID_WriteEnable, bus_a.IFID_Flush, bus_a.IDEX_Flush,
               bus_a.StageWriteEnable};
      o_hs = bus_a.HazardState; o_err = bus_a.MemError;
`ifdef HAZARD_PERF_COUNTERS_EN
      o_st = bus_a.StallCycles; o_fl = 32'(bus_a.FlushCount);
`endif
    end else begin
      o_ctl = {bus_b.PCWrite, bus_b.IFID_WriteEnable, bus_b.IFID_Flush, bus_b.IDEX_Flush,
               bus_b.StageWriteEnable};
      o_hs = bus_b.HazardState; o_err = bus_b.MemError;
`ifdef HAZARD_PERF_COUNTERS_EN
      o_st = bus_b.StallCycles; o_fl = 32'(bus_b.FlushCount);
`endif
    end
  endtask

  // Inputs were set after the last rising edge; sample on the falling edge.
  task automatic step();
    logic [6:0]  e_ctl, o_ctl;
    int          e_hs, e_err, e_st, e_fl;
    logic [1:0]  o_hs;
    logic        o_err;
    logic [31:0] o_st, o_fl;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      get_obs(k, o_ctl, o_hs, o_err, o_st, o_fl);
      model_step(k, e_ctl, e_hs, e_err, e_st, e_fl);
      check($sformatf("c%0d.dut%0d.controls", cycle, k), 32'(o_ctl), 32'(e_ctl));
      check($sformatf("c%0d.dut%0d.state", cycle, k), 32'(o_hs), 32'(e_hs));
      check($sformatf("c%0d.dut%0d.memerror", cycle, k), 32'(o_err), 32'(e_err));
`ifdef HAZARD_PERF_COUNTERS_EN
      check($sformatf("c%0d.dut%0d.stallcycles", cycle, k), o_st, 32'(e_st));
      check($sformatf("c%0d.dut%0d.flushcount", cycle, k), o_fl, 32'(e_fl));
`endif
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic clear_inputs();
    ifid_rs = '0; ifid_rt = '0; idex_rt = '0; ifid_uses_rt = 1'b0;
    idex_mem_read = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic random_inputs(input int req_pct, input int ready_pct);
    ifid_rs       = 5'($urandom_range(0, 3));
    ifid_rt       = 5'($urandom_range(0, 3));
    idex_rt       = 5'($urandom_range(0, 3));
    ifid_uses_rt  = ($urandom_range(0, 1) == 1);
    idex_mem_read = ($urandom_range(0, 2) == 0);
    branch_taken  = ($urandom_range(0, 7) == 0);
    jump          = ($urandom_range(0, 7) == 0);
    mem_req       = ($urandom_range(0, 99) < req_pct);
    mem_ready     = ($urandom_range(0, 99) < ready_pct);
    rst           = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    clear_inputs();
    // Reset for two cycles, then IDLE followed by RUN.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step(); step();

    // Load-use on r5 through rs, then normal flow.
    idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    step(); clear_inputs(); step(); step(); step();
    // Register 0 never causes a hazard.
    idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    step(); clear_inputs(); step();
    // Hazard through rt only when rt is a source.
    idex_mem_read = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7; ifid_uses_rt = 1'b1;
    step(); clear_inputs(); step(); step(); step();
    idex_mem_read = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7; ifid_uses_rt = 1'b0;
    step(); clear_inputs(); step();

    // Load-use with a taken branch, then a lone jump.
    idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; branch_taken = 1'b1;
    step(); clear_inputs(); step();
    jump = 1'b1;
    step(); clear_inputs(); step();

    // Three-cycle memory wait, then ready.
    mem_req = 1'b1;
    step(); step(); step();
    mem_ready = 1'b1;
    step(); clear_inputs(); step();

    // Branch held through a wait.
    mem_req = 1'b1; branch_taken = 1'b1;
    step(); step(); step();
    mem_ready = 1'b1;
    step(); clear_inputs(); step();

    // Memory wait interrupting a multi-bubble stall.
    idex_mem_read = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
    step(); clear_inputs(); mem_req = 1'b1;
    step(); step();
    mem_ready = 1'b1;
    step(); clear_inputs(); step(); step(); step();

    // Memory never ready: timeouts on both instances, then reset mid-wait.
    mem_req = 1'b1;
    repeat (18) step();
    mem_req = 1'b0;
    step(); step();
    mem_req = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; clear_inputs();
    step(); step(); step();

    // Random traffic: mixed, memory-heavy, then slow memory for long waits.
    for (int i = 0; i < 700; i++) begin random_inputs(25, 50); step(); end
    for (int i = 0; i < 500; i++) begin random_inputs(60, 30); step(); end
    for (int i = 0; i < 500; i++) begin random_inputs(70, 3);  step(); end

    rst = 1'b1; clear_inputs();
    step();
    rst = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
